// File: rtl/imm_operand_encoder.sv
// Iterative ARM data-processing immediate encoder: finds {rotate_imm, immed_8} such that
// immed_8 rotated right by 2*rotate_imm equals the constant, optionally via its complement.
module imm_operand_encoder #(
    parameter bit ALLOW_INVERT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] value_in,
    output logic        busy,
    output logic        done,
    output logic        encodable,
    output logic        inverted,
    output logic [11:0] shifter_operand_out
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t      state;
    logic [31:0] val;
    logic [3:0]  r;
    logic        phase;
    logic [4:0]  amt;
    logic [31:0] cand;
    logic        hit;

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] d;
        d = {x, x} << n;
        return d[63:32];
    endfunction

    // Rotating left by 2r undoes the decoder's rotate-right; a hit leaves only immed_8 bits.
    assign amt  = {r, 1'b0};
    assign cand = rotl(val, amt);
    assign hit  = (cand[31:8] == 24'd0);

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            val <= value_in;
        end else if (state == SEARCH && !hit && r == 4'hF && !phase && ALLOW_INVERT) begin
            val <= ~val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= IDLE;
            r                   <= 4'd0;
            phase               <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            encodable           <= 1'b0;
            inverted            <= 1'b0;
            shifter_operand_out <= 12'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        r     <= 4'd0;
                        phase <= 1'b0;
                        busy  <= 1'b1;
                        state <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (hit) begin
                        shifter_operand_out <= {r, cand[7:0]};
                        encodable           <= 1'b1;
                        inverted            <= phase;
                        done                <= 1'b1;
                        state               <= DONE;
                    end else if (r != 4'hF) begin
                        r <= r + 4'd1;
                    end else if (!phase && ALLOW_INVERT) begin
                        r     <= 4'd0;
                        phase <= 1'b1;
                    end else begin
                        shifter_operand_out <= 12'd0;
                        encodable           <= 1'b0;
                        inverted            <= 1'b0;
                        done                <= 1'b1;
                        state               <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_operand_encoder.sv
// Bench for imm_operand_encoder: two instances (with and without complement retry) checked
// every cycle against a decode-based reference model, plus directed literal vectors.
module tb_imm_operand_encoder;

    logic        clk;
    logic        rst;
    logic [1:0]  start;
    logic [31:0] value_in [2];
    logic [1:0]  busy, done, encodable, inverted;
    logic [11:0] op [2];

    int tests = 0;
    int fails = 0;

    imm_operand_encoder #(.ALLOW_INVERT(1'b1)) dut_inv (
        .clk(clk), .rst(rst), .start(start[0]), .value_in(value_in[0]),
        .busy(busy[0]), .done(done[0]), .encodable(encodable[0]), .inverted(inverted[0]),
        .shifter_operand_out(op[0])
    );

    imm_operand_encoder #(.ALLOW_INVERT(1'b0)) dut_dir (
        .clk(clk), .rst(rst), .start(start[1]), .value_in(value_in[1]),
        .busy(busy[1]), .done(done[1]), .encodable(encodable[1]), .inverted(inverted[1]),
        .shifter_operand_out(op[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the smallest (phase, r) whose decoded immediate reproduces the target.
    function automatic void model(input logic [31:0] v, input bit inv_ok, output bit enc,
                                  output bit inv, output logic [11:0] opnd, output int lat);
        logic [63:0] d;
        logic [31:0] t, x;
        enc  = 1'b0;
        inv  = 1'b0;
        opnd = 12'd0;
        lat  = inv_ok ? 32 : 16;
        for (int p = 0; p < (inv_ok ? 2 : 1); p++) begin
            t = (p == 1) ? ~v : v;
            for (int k = 0; k < 16; k++) begin
                if (!enc) begin
                    d = {t, t} << (2 * k);
                    x = {24'd0, d[39:32]};
                    d = {x, x} >> (2 * k);
                    if (d[31:0] == t) begin
                        enc  = 1'b1;
                        inv  = (p == 1);
                        opnd = {k[3:0], x[7:0]};
                        lat  = 16 * p + k + 1;
                    end
                end
            end
        end
    endfunction

    // Inputs as seen by the DUTs on each rising edge.
    logic        s_rst;
    logic [1:0]  s_start;
    logic [31:0] s_val [2];
    always @(posedge clk) begin
        s_rst    <= rst;
        s_start  <= start;
        s_val[0] <= value_in[0];
        s_val[1] <= value_in[1];
    end

    bit          mb [2], md [2], me [2], mi [2], pe [2], pi [2];
    logic [11:0] mo [2], po [2];
    int          mcnt [2];

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst || !s_rst) begin
                mb[m] = 0; md[m] = 0; me[m] = 0; mi[m] = 0; mo[m] = 12'd0; mcnt[m] = 0;
            end else if (md[m]) begin
                md[m] = 0;
                mb[m] = 0;
            end else if (mb[m]) begin
                mcnt[m]--;
                if (mcnt[m] == 0) begin
                    md[m] = 1; me[m] = pe[m]; mi[m] = pi[m]; mo[m] = po[m];
                end
            end else if (s_start[m]) begin
                mb[m] = 1;
                model(s_val[m], (m == 0), pe[m], pi[m], po[m], mcnt[m]);
            end
            chk($sformatf("busy%0d", m), busy[m], mb[m]);
            chk($sformatf("done%0d", m), done[m], md[m]);
            chk($sformatf("encodable%0d", m), encodable[m], me[m]);
            chk($sformatf("inverted%0d", m), inverted[m], mi[m]);
            chk($sformatf("operand%0d", m), op[m], mo[m]);
        end
    end

    task automatic run(input int m, input logic [31:0] v, input bit e_enc, input bit e_inv,
                       input logic [11:0] e_op, input int e_lat, input bit poke, output int acc);
        int n;
        @(negedge clk); #1;
        start[m]    = 1'b1;
        value_in[m] = v;
        acc = 0;
        do begin
            @(posedge clk); #1;
            acc++;
        end while (!busy[m] && acc < 4);
        start[m]    = 1'b0;
        value_in[m] = ~v;
        chk("accepted", busy[m], 1'b1);
        n = 0;
        do begin
            if (poke && n >= 2 && n <= 5) begin
                start[m]    = 1'b1;
                value_in[m] = 32'h1;
            end else begin
                start[m] = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end while (!done[m] && n < 40);
        start[m] = 1'b0;
        chk($sformatf("done_seen %h", v), done[m], 1'b1);
        chk($sformatf("latency %h", v), n, e_lat);
        chk($sformatf("enc %h", v), encodable[m], e_enc);
        chk($sformatf("inv %h", v), inverted[m], e_inv);
        chk($sformatf("op %h", v), op[m], e_op);
    endtask

    initial begin
        bit          e, i;
        logic [11:0] o;
        int          l, acc;

        rst = 1'b1;
        start = 2'b00;
        value_in[0] = 32'd0;
        value_in[1] = 32'd0;
        #2 rst = 1'b0;

        // Pin the reference model on hand-derived encodings.
        model(32'h000000FF, 1, e, i, o, l); chk("m_ff_op", o, 12'h0FF); chk("m_ff_lat", l, 1);
        model(32'hFF000000, 1, e, i, o, l); chk("m_ff0_op", o, 12'h4FF); chk("m_ff0_lat", l, 5);
        model(32'h000003FC, 1, e, i, o, l); chk("m_3fc_op", o, 12'hFFF); chk("m_3fc_lat", l, 16);
        model(32'hFFFFFF00, 1, e, i, o, l); chk("m_inv_i", i, 1); chk("m_inv_lat", l, 17);
        model(32'hFFFFFF00, 0, e, i, o, l); chk("m_noinv_e", e, 0); chk("m_noinv_lat", l, 16);
        model(32'h00000101, 1, e, i, o, l); chk("m_101_e", e, 0); chk("m_101_lat", l, 32);

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 2'b00);
        chk("rst_op0", op[0], 12'd0);
        #1 rst = 1'b1;

        run(0, 32'h000000FF, 1, 0, 12'h0FF, 1, 0, acc);
        chk("idle_accept", acc, 1);
        run(0, 32'h00000000, 1, 0, 12'h000, 1, 0, acc);
        run(0, 32'hFF000000, 1, 0, 12'h4FF, 5, 0, acc);
        run(0, 32'h000003FC, 1, 0, 12'hFFF, 16, 1, acc);
        run(0, 32'hFFFFFF00, 1, 1, 12'h0FF, 17, 0, acc);
        run(1, 32'hFFFFFF00, 0, 0, 12'h000, 16, 0, acc);
        run(1, 32'h000003FC, 1, 0, 12'hFFF, 16, 0, acc);
        run(0, 32'h00000101, 0, 0, 12'h000, 32, 0, acc);
        run(1, 32'h00000101, 0, 0, 12'h000, 16, 0, acc);
        run(0, 32'hFF000000, 1, 0, 12'h4FF, 5, 0, acc);
        run(0, 32'h000000FF, 1, 0, 12'h0FF, 1, 0, acc);
        chk("b2b_accept", acc, 2);

        // Asynchronous reset in the middle of a long search.
        @(negedge clk); #1;
        start[0] = 1'b1;
        value_in[0] = 32'h00000101;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (8) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_busy", busy[0], 1'b0);
        chk("arst_done", done[0], 1'b0);
        chk("arst_enc", encodable[0], 1'b0);
        chk("arst_op", op[0], 12'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        run(0, 32'h000000FF, 1, 0, 12'h0FF, 1, 0, acc);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
